fetch_decode_stage: RTL

//  Owns the PC register, the IF/ID pipeline register and load-use/branch hazard detection.

---
 rtl/fetch_decode_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch stage of the MIPS pipeline. It holds the PC, the IF/ID register, stall detection
// for load-use and ID-resolved branches, redirect/flush handling and the fetch halt FSM.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_instr_addr,
    input  logic [31:0] i_instr_data,
    input  logic [1:0]  i_jb_flag,
    input  logic [31:0] i_branch_addr,
    input  logic [31:0] i_j_addr,
    input  logic        i_idex_mem_read,
    input  logic [4:0]  i_idex_rt,
    input  logic        i_idex_reg_wr,
    input  logic [4:0]  i_idex_wr_reg,
    input  logic        i_exmem_mem_read,
    input  logic [4:0]  i_exmem_wr_reg,
    output logic [5:0]  o_op,
    output logic [5:0]  o_funct,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [31:0] o_sign_imm,
    output logic [25:0] o_j_raw_addr,
    output logic [31:0] o_pc_plus4,
    output logic        o_id_valid,
    output logic        o_ctl_mux,
    output logic        o_halted
);

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [5:0]  FN_JR    = 6'h08;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc4_next;
    logic        w_valid_next;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_is_jr;
    logic        w_is_cmp_branch;
    logic        w_is_br;
    logic        w_uses_rt;
    logic        w_load_use;
    logic        w_br_alu;
    logic        w_br_load;
    logic        w_stall;
    logic        w_take_branch;
    logic        w_take_jump;
    logic        w_seq;
    logic        w_halt_hit;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic        w_unused;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    assign w_op    = r_ifid_instr[31:26];
    assign w_funct = r_ifid_instr[5:0];
    assign w_rs    = r_ifid_instr[25:21];
    assign w_rt    = r_ifid_instr[20:16];

    assign w_is_jr         = (w_op == OP_RTYPE) && (w_funct == FN_JR);
    assign w_is_cmp_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_is_br         = w_is_cmp_branch || w_is_jr;
    assign w_uses_rt       = ((w_op == OP_RTYPE) && !w_is_jr) || w_is_cmp_branch || (w_op == OP_SW);

    assign w_load_use = i_idex_mem_read &&
                        (reg_hit(i_idex_rt, w_rs) || (w_uses_rt && reg_hit(i_idex_rt, w_rt)));
    // JR only reads rs; beq/bne compare both sources in ID.
    assign w_br_alu   = w_is_br && i_idex_reg_wr &&
                        (reg_hit(i_idex_wr_reg, w_rs) || (w_is_cmp_branch && reg_hit(i_idex_wr_reg, w_rt)));
    assign w_br_load  = w_is_br && i_exmem_mem_read &&
                        (reg_hit(i_exmem_wr_reg, w_rs) || (w_is_cmp_branch && reg_hit(i_exmem_wr_reg, w_rt)));
    assign w_stall    = r_ifid_valid && (w_load_use || w_br_alu || w_br_load);

    // A stalled ID instruction has stale operands, so its branch decision is not trusted.
    assign w_take_branch = !w_stall && (i_jb_flag == 2'b01);
    assign w_take_jump   = !w_stall && (i_jb_flag == 2'b10);
    assign w_seq         = !w_stall && !w_take_branch && !w_take_jump && (r_state == ST_RUN);
    assign w_halt_hit    = w_seq && (i_instr_data == HALT_WORD);

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_tgt = {i_branch_addr[31:2], 2'b00};
    assign w_jump_tgt   = {i_j_addr[31:2], 2'b00};
    assign w_unused     = ^{i_branch_addr[1:0], i_j_addr[1:0]};

    always_comb begin
        w_pc_next    = r_pc;
        w_instr_next = r_ifid_instr;
        w_pc4_next   = r_ifid_pc4;
        w_valid_next = r_ifid_valid;
        if (w_take_branch) begin
            w_pc_next    = w_branch_tgt;
            w_instr_next = NOP_WORD;
            w_valid_next = 1'b0;
        end else if (w_take_jump) begin
            w_pc_next    = w_jump_tgt;
            w_instr_next = NOP_WORD;
            w_valid_next = 1'b0;
        end else if (!w_stall && (r_state == ST_HALT)) begin
            w_instr_next = NOP_WORD;
            w_valid_next = 1'b0;
        end else if (w_seq) begin
            w_pc_next  = w_pc_plus4;
            w_pc4_next = w_pc_plus4;
            if (w_halt_hit) begin
                w_instr_next = NOP_WORD;
                w_valid_next = 1'b0;
            end else begin
                w_instr_next = i_instr_data;
                w_valid_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_RUN) && w_halt_hit) begin
            w_state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_instr_next;
            r_ifid_pc4   <= w_pc4_next;
            r_ifid_valid <= w_valid_next;
        end
    end

    assign o_instr_addr = r_pc;
    assign o_op         = w_op;
    assign o_funct      = w_funct;
    assign o_rs         = w_rs;
    assign o_rt         = w_rt;
    assign o_rd         = r_ifid_instr[15:11];
    assign o_sign_imm   = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    assign o_j_raw_addr = r_ifid_instr[25:0];
    assign o_pc_plus4   = r_ifid_pc4;
    assign o_id_valid   = r_ifid_valid;
    assign o_ctl_mux    = w_stall;
    assign o_halted     = (r_state == ST_HALT);

endmodule
